// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, including branch predictor state and BTB entry layout
package cpu_types_pkg;
  localparam int BTB_WORD_W = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W = BTB_WORD_W - BTB_IDX_W - 2;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_ctr_t;
  typedef struct packed {
    logic valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_WORD_W-1:0] target;
    bp_ctr_t ctr;
  } btb_entry_t;
endpackage

// File: rtl/btb_if.sv
// btb_if: fetch-side lookup and EX-side resolution bundle for the branch target buffer
interface btb_if #(parameter int WORD_W = 32);
  logic f_en;
  logic [WORD_W-1:0] f_pc;
  logic f_hit;
  logic f_taken;
  logic [WORD_W-1:0] f_target;
  logic [WORD_W-1:0] f_next_pc;
  logic u_valid;
  logic u_uncond;
  logic [WORD_W-1:0] u_pc;
  logic u_taken;
  logic [WORD_W-1:0] u_target;
  logic u_pred_taken;
  logic [WORD_W-1:0] u_pred_target;
  logic mispredict;
  logic [WORD_W-1:0] redirect_pc;
  modport fetch (output f_en, f_pc, input f_hit, f_taken, f_target, f_next_pc);
  modport ex (output u_valid, u_uncond, u_pc, u_taken, u_target, u_pred_taken, u_pred_target,
              input mispredict, redirect_pc);
endinterface

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating up/down direction counter
module sat_counter2
  import cpu_types_pkg::*;
(
  input  bp_ctr_t cur,
  input  logic    up,
  output bp_ctr_t nxt
);
  always_comb nxt = up ? (cur == ST ? ST : bp_ctr_t'(cur + 2'd1))
                       : (cur == SNT ? SNT : bp_ctr_t'(cur - 2'd1));
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters and saturating statistics
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              f_en,
  input  logic [WORD_W-1:0] f_pc,
  output logic              f_hit,
  output logic              f_taken,
  output logic [WORD_W-1:0] f_target,
  output logic [WORD_W-1:0] f_next_pc,
  input  logic              u_valid,
  input  logic              u_uncond,
  input  logic [WORD_W-1:0] u_pc,
  input  logic              u_taken,
  input  logic [WORD_W-1:0] u_target,
  input  logic              u_pred_taken,
  input  logic [WORD_W-1:0] u_pred_target,
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc,
  input  logic              clear,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [WORD_W-1:0] target;
    bp_ctr_t ctr;
  } entry_t;
  entry_t mem [ENTRIES];
  entry_t fe, ue;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic u_hit;
  bp_ctr_t ctr_nxt;
  always_comb begin
    f_idx = f_pc[IDX_W+1:2];
    u_idx = u_pc[IDX_W+1:2];
    fe = mem[f_idx];
    ue = mem[u_idx];
    f_hit = fe.valid && fe.tag == f_pc[WORD_W-1:IDX_W+2];
    f_taken = f_hit && fe.ctr[1];
    f_target = f_hit ? fe.target : '0;
    f_next_pc = f_taken ? f_target : f_pc + WORD_W'(4);
    u_hit = ue.valid && ue.tag == u_pc[WORD_W-1:IDX_W+2];
    mispredict = u_valid && ((u_taken != u_pred_taken) || (u_taken && u_target != u_pred_target));
    redirect_pc = u_taken ? u_target : u_pc + WORD_W'(4);
  end
  sat_counter2 u_ctr (.cur(ue.ctr), .up(u_taken), .nxt(ctr_nxt));
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (u_valid) begin
      if (u_hit) begin
        mem[u_idx].ctr <= u_uncond ? ST : ctr_nxt;
        if (u_uncond || u_taken) mem[u_idx].target <= u_target;
      end else if (u_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: u_pc[WORD_W-1:IDX_W+2], target: u_target, ctr: u_uncond ? ST : WT};
      end
    end
  end
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      hit_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      if (f_en && f_hit && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (mispredict && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed plus random stimulus scored against a behavioural BTB model
module tb_branch_target_buffer;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic f_en = 1'b0;
  logic [31:0] f_pc = '0;
  logic f_hit, f_taken, mispredict;
  logic [31:0] f_target, f_next_pc, redirect_pc;
  logic u_valid = 1'b0, u_uncond = 1'b0, u_taken = 1'b0, u_pred_taken = 1'b0, clear = 1'b0;
  logic [31:0] u_pc = '0, u_target = '0, u_pred_target = '0;
  logic [3:0] hit_cnt, mispred_cnt;
  always #5 CLK = ~CLK;
  branch_target_buffer #(.ENTRIES(16), .WORD_W(32), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .f_en(f_en), .f_pc(f_pc), .f_hit(f_hit), .f_taken(f_taken),
    .f_target(f_target), .f_next_pc(f_next_pc), .u_valid(u_valid), .u_uncond(u_uncond),
    .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target), .u_pred_taken(u_pred_taken),
    .u_pred_target(u_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .clear(clear), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt));
  typedef struct {
    logic hit, taken, mp;
    logic [31:0] tgt, npc, rpc;
    logic [3:0] hc, mc;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  bit mv[16];
  logic [25:0] mtag[16];
  logic [31:0] mtgt[16];
  int mctr[16];
  int hc, mc;
  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      mtag[i] = '0;
      mtgt[i] = '0;
      mctr[i] = 1;
    end
    hc = 0;
    mc = 0;
  endtask
  task automatic step(input logic rstn, input logic en, input logic [31:0] fpc, input logic uv,
                      input logic uu, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                      input logic upt, input logic [31:0] uptg, input logic clr);
    exp_t e;
    int fi, ui;
    bit uh;
    @(negedge CLK);
    nRST = rstn; f_en = en; f_pc = fpc; u_valid = uv; u_uncond = uu; u_pc = upc;
    u_taken = ut; u_target = utg; u_pred_taken = upt; u_pred_target = uptg; clear = clr;
    if (!rstn) m_reset();
    fi = int'(fpc[5:2]);
    e.hit = mv[fi] && mtag[fi] == fpc[31:6];
    e.taken = e.hit && mctr[fi] >= 2;
    e.tgt = e.hit ? mtgt[fi] : 32'h0;
    e.npc = e.taken ? e.tgt : fpc + 32'd4;
    e.mp = uv && (ut != upt || (ut && utg != uptg));
    e.rpc = ut ? utg : upc + 32'd4;
    e.hc = 4'(hc);
    e.mc = 4'(mc);
    q.push_back(e);
    if (rstn) begin
      if (en && e.hit && hc < 15) hc++;
      if (e.mp && mc < 15) mc++;
      if (clr) begin
        for (int i = 0; i < 16; i++) mv[i] = 0;
      end else if (uv) begin
        ui = int'(upc[5:2]);
        uh = mv[ui] && mtag[ui] == upc[31:6];
        if (uh && uu) begin
          mctr[ui] = 3;
          mtgt[ui] = utg;
        end else if (uh) begin
          mctr[ui] = ut ? (mctr[ui] == 3 ? 3 : mctr[ui] + 1) : (mctr[ui] == 0 ? 0 : mctr[ui] - 1);
          if (ut) mtgt[ui] = utg;
        end else if (ut) begin
          mv[ui] = 1;
          mtag[ui] = upc[31:6];
          mtgt[ui] = utg;
          mctr[ui] = uu ? 3 : 2;
        end
      end
    end
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %h want %h", name, vectors, got, want);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        check("f_hit", 32'(f_hit), 32'(e.hit));
        check("f_taken", 32'(f_taken), 32'(e.taken));
        check("f_target", f_target, e.tgt);
        check("f_next_pc", f_next_pc, e.npc);
        check("mispredict", 32'(mispredict), 32'(e.mp));
        check("redirect_pc", redirect_pc, e.rpc);
        check("hit_cnt", 32'(hit_cnt), 32'(e.hc));
        check("mispred_cnt", 32'(mispred_cnt), 32'(e.mc));
      end
    end
  end
  initial begin
    logic [31:0] fpc, upc, utg;
    logic uu, ut;
    m_reset();
    step(0, 0, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h40, 1, 0, 32'h40, 1, 32'h100, 0, 32'h0, 0);
    step(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 32'h40, 1, 0, 32'h40, 0, 32'h0, 1, 32'h100, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h40, 1, 0, 32'h40, 1, 32'h100, 0, 32'h0, 0);
    step(1, 1, 32'h80, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h80, 1, 0, 32'h80, 1, 32'h200, 1, 32'h200, 0);
    step(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 32'h40, 1, 0, 32'h40, 1, 32'h300, 1, 32'h300, 1);
    step(1, 1, 32'h40, 1, 0, 32'h40, 1, 32'h300, 0, 32'h0, 0);
    step(1, 1, 32'h40, 1, 0, 32'h40, 0, 32'h0, 1, 32'h300, 0);
    step(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 32'h43, 1, 1, 32'h41, 1, 32'h500, 0, 32'h0, 0);
    step(1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 32'h40, 1, 0, 32'h40, 1, 32'h600, 0, 32'h0, 0);
    for (int i = 0; i < 400; i++) begin
      fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      uu = ($urandom_range(0, 3) == 0);
      ut = uu | 1'($urandom_range(0, 1));
      utg = $urandom & 32'hFFFF_FFFC;
      step(i != 200 && i != 201, 1'($urandom_range(0, 1)), fpc, 1'($urandom_range(0, 3) != 0), uu,
           upc, ut, utg, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom : utg,
           $urandom_range(0, 40) == 0);
    end
    @(negedge CLK);
    #4;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised branch target buffer with 2-bit saturating direction predictors for the pipelined datapath fetch stage.
- Fetch looks up the current PC combinationally and gets a predicted next PC, so taken branches and jumps no longer cost a flush in the common case.
- EX-stage resolution writes the outcome back and gets a mispredict flag and a redirect PC.
- Keeps saturating hit and mispredict statistics.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, at least 2; IDX_W = log2(ENTRIES).
WORD_W, 32, PC and target width.
CNT_W, 32, width of each statistics counter.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
f_en  in  1  fetch advancing this cycle (ihit); qualifies statistics only
f_pc  in  WORD_W  current fetch PC
f_hit  out  1  valid entry with matching tag at f_pc
f_taken  out  1  prediction is taken
f_target  out  WORD_W  stored target (0 on miss)
f_next_pc  out  WORD_W  f_taken ? f_target : f_pc+4
u_valid  in  1  a branch or jump resolved in EX this cycle
u_uncond  in  1  resolved instruction is J/JAL/JR
u_pc  in  WORD_W  PC of the resolved instruction
u_taken  in  1  actual direction
u_target  in  WORD_W  actual target
u_pred_taken  in  1  prediction carried down the pipe
u_pred_target  in  WORD_W  predicted next PC carried down the pipe
mispredict  out  1  redirect required (combinational)
redirect_pc  out  WORD_W  u_taken ? u_target : u_pc+4
clear  in  1  synchronous invalidate of all entries
hit_cnt  out  CNT_W  saturating count of fetches with f_en & f_hit
mispred_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Entry fields: valid, tag = pc[WORD_W-1:IDX_W+2], target[WORD_W-1:0], ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff hit & ctr[1].
- Lookup is purely combinational from registered state: zero latency.
- On a miss: f_taken=0, f_target=0, f_next_pc=f_pc+4. All +4 arithmetic wraps modulo 2^WORD_W.
- Update on a clock edge when u_valid=1 and clear=0:
  - Hit, conditional: ctr saturating +1 if taken, saturating -1 if not. Target written only when taken.
  - Hit, u_uncond: ctr=11, target=u_target.
  - Miss and taken: allocate; this overwrites any aliasing entry. valid=1, tag, target written; ctr=11 if u_uncond, else 10.
  - Miss and not taken: no change.
- mispredict = u_valid & ((u_taken != u_pred_taken) | (u_taken & (u_target != u_pred_target))). Combinational; the datapath uses it as flush plus pc_next override.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents. No write-through bypass.
- clear=1: all valid bits cleared at the edge. clear beats a simultaneous update. Statistics are not cleared.
- Statistics:
  - hit_cnt increments on the edge when f_en & f_hit.
  - mispred_cnt increments on the edge when mispredict.
  - Both hold at all-ones once saturated.
- Reset (asynchronous, any time including mid-update): all valid=0, ctr=01, target=0, tag=0, hit_cnt=0, mispred_cnt=0. Outputs are therefore f_hit=0, f_taken=0, f_target=0, f_next_pc=f_pc+4. mispredict and redirect_pc follow the u_* inputs.
- No handshake stalls: the block always accepts updates and never backpressures fetch.

Decomposition:
- cpu_types_pkg gains: bp_ctr_t (2-bit enum SNT/WNT/WT/ST) and btb_entry_t (packed valid/tag/target/ctr).
- The tag width is computed locally from the parameters.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down counter. Statistics counters stay inline.
- A btb_if interface with fetch and ex modports matches existing datapath practice.

Test Plan:
1. Reset, f_pc=0x40 -> f_hit=0, f_taken=0, f_next_pc=0x44, hit_cnt=0, mispred_cnt=0.
2. Taken-branch update:
   - Stimulus: u_valid, u_pc=0x40, u_taken=1, u_target=0x100, u_pred_taken=0.
   - Same cycle: mispredict=1, redirect_pc=0x100.
   - Next cycle, f_pc=0x40, f_en=1: f_hit=1, f_taken=1 (ctr 10), f_next_pc=0x100, hit_cnt=1.
3. Counter decay: from step 2 send one not-taken update of 0x40 -> ctr 01, f_taken=0, f_next_pc=0x44, f_hit=1. Then three taken updates -> ctr 11, and a fourth taken update stays 11.
4. Aliasing with ENTRIES=16: entry at 0x40; lookup 0x80 (same index 0, different tag) -> f_hit=0. Taken update at 0x80, target 0x200 -> lookup 0x40 now misses.
5. Same edge clear=1 and u_valid=1 with taken at 0x40 -> next cycle f_hit=0 for 0x40; hit_cnt unchanged.
6. Same-cycle lookup and update at index 0x40: f_next_pc still shows the old prediction that cycle and the new one the next cycle. Also preload mispred_cnt near all-ones (CNT_W=4 build) and force mispredicts -> holds at 0xF.
